// File: rtl/enemy_hit_judge.sv
// enemy_hit_judge: one descending enemy sprite. Checks bullet/enemy overlap
// once per game tick, drives the alive/explode/respawn/over life cycle,
// keeps a 4-digit BCD score and a lives count, and produces the enemy's
// pixel enable and colour for a 640x480 screen.
//
// state   | meaning
// ALIVE   | enemy descends one line per tick, hit and escape are tested
// EXPLODE | enemy frozen, explosion counter runs down once per tick
// RESPAWN | one tick: enemy moves to the top row at a pseudo-random x
// OVER    | no lives left; everything frozen until reset
module enemy_hit_judge #(
  parameter int ENEMY_W    = 46,
  parameter int ENEMY_H    = 40,
  parameter int BULLET_W   = 4,
  parameter int BULLET_H   = 40,
  parameter int BOOM_TICKS = 16,
  parameter int LIVES_INIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [9:0]  e_x,
  output logic [9:0]  e_y,
  output logic        boom,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        enemy_en,
  output logic [11:0] enemy_rgb
);

  localparam logic [1:0] ST_ALIVE   = 2'd0;
  localparam logic [1:0] ST_EXPLODE = 2'd1;
  localparam logic [1:0] ST_RESPAWN = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [10:0] ESCAPE_Y  = 11'(480 - ENEMY_H);
  localparam logic [10:0] EW        = 11'(ENEMY_W);
  localparam logic [10:0] EH        = 11'(ENEMY_H);
  localparam logic [10:0] BW        = 11'(BULLET_W);
  localparam logic [10:0] BH        = 11'(BULLET_H);
  localparam logic [7:0]  BOOM_LOAD = 8'(BOOM_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  e_x_q, e_x_d;
  logic [9:0]  e_y_q, e_y_d;
  logic        boom_q, boom_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        game_over_q, game_over_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  lfsr_q, lfsr_d;

  logic [10:0] ex11, ey11, bx11, by11, b_top;
  logic        b_on, hit, escape;

  // BCD +1 with digit carry ripple; 9999 saturates
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Overlap and escape tests on 11-bit zero-extended coordinates
  always_comb begin
    ex11   = {1'b0, e_x_q};
    ey11   = {1'b0, e_y_q};
    bx11   = {1'b0, b_x};
    by11   = {1'b0, b_y};
    b_on   = (by11 >= SCREEN_H);
    b_top  = by11 - SCREEN_H;
    hit    = b_on && (bx11 < ex11 + EW) && (ex11 < bx11 + BW) &&
             (b_top < ey11 + EH) && (ey11 < b_top + BH);
    escape = (ey11 + 11'd1 >= ESCAPE_Y);
  end

  // Next-state logic; only lfsr moves on non-tick cycles
  always_comb begin
    state_d = state_q;
    e_x_d   = e_x_q;
    e_y_d   = e_y_q;
    boom_d  = 1'b0;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    if (tick) begin
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            boom_d  = 1'b1;
            state_d = ST_EXPLODE;
            cnt_d   = BOOM_LOAD;
            score_d = bcd_inc(score_q);
          end else if (escape) begin
            lives_d = lives_q - 2'd1;
            state_d = (lives_q == 2'd1) ? ST_OVER : ST_RESPAWN;
          end else begin
            e_y_d = e_y_q + 10'd1;
          end
        end
        ST_EXPLODE: begin
          if (cnt_q == 8'd0) state_d = ST_RESPAWN;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_RESPAWN: begin
          e_y_d   = 10'd0;
          e_x_d   = {1'b0, lfsr_q[8:0]};
          state_d = ST_ALIVE;
        end
        default: ;
      endcase
    end
    game_over_d = (state_d == ST_OVER);
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ALIVE;
      e_x_q       <= 10'd297;
      e_y_q       <= 10'd0;
      boom_q      <= 1'b0;
      score_q     <= 16'h0000;
      lives_q     <= 2'(LIVES_INIT);
      game_over_q <= 1'b0;
      cnt_q       <= 8'd0;
      lfsr_q      <= 10'h2A5;
    end else begin
      state_q     <= state_d;
      e_x_q       <= e_x_d;
      e_y_q       <= e_y_d;
      boom_q      <= boom_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Pixel enable and colour from the current pixel and registered state
  always_comb begin
    enemy_en = ({1'b0, x} >= ex11) && ({1'b0, x} < ex11 + EW) &&
               ({1'b0, y} >= ey11) && ({1'b0, y} < ey11 + EH) &&
               ((state_q == ST_ALIVE) || (state_q == ST_EXPLODE));
    case (state_q)
      ST_ALIVE:   enemy_rgb = 12'hF00;
      ST_EXPLODE: enemy_rgb = 12'hFF0;
      default:    enemy_rgb = 12'h000;
    endcase
  end

  assign e_x       = e_x_q;
  assign e_y       = e_y_q;
  assign boom      = boom_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule
